// File: rtl/branch_pc_unit_pkg.sv
// -----------------------------------------------------------------------------
// branch_pc_unit_pkg
// Shared definitions for the branch / program-counter stage of the
// single-cycle RISC-V core.
//   - funct3 condition codes for the conditional branches
//   - default reset PC
//   - instruction alignment mask plus a helper that applies it
// -----------------------------------------------------------------------------
package branch_pc_unit_pkg;

   // RISC-V branch condition codes carried in funct3.
   // Codes 3'b010 and 3'b011 are unused by the ISA.
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // PC value loaded when the core comes out of reset.
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Instructions are 32-bit words.  No compressed extension is supported,
   // so both low address bits must be zero.
   localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

   // True when the two low address bits describe a legal instruction address.
   function automatic logic word_aligned(input logic [1:0] low_bits);
      return (low_bits & INSTR_ALIGN_MASK) == 2'b00;
   endfunction

endpackage

// File: rtl/branch_pc_unit_if.sv
// -----------------------------------------------------------------------------
// branch_pc_unit_if
// Bundles the decode-side inputs and the fetch-side outputs of the branch /
// PC stage.
//   master : the decode stage (drives the instruction fields and operands,
//            observes the PC, the link value and the trap state)
//   slave  : branch_pc_unit itself
// Signals:
//   en, is_branch, is_jal, is_jalr, funct3, Data0, Data1, imm  (master -> slave)
//   pc, pc_plus4, taken, misalign_err, err_pc, taken_count     (slave -> master)
// -----------------------------------------------------------------------------
interface branch_pc_unit_if #(
   parameter int N     = 32,
   parameter int CNT_W = 16
);

   logic             en;
   logic             is_branch;
   logic             is_jal;
   logic             is_jalr;
   logic [2:0]       funct3;
   logic [N-1:0]     Data0;
   logic [N-1:0]     Data1;
   logic [N-1:0]     imm;

   logic [N-1:0]     pc;
   logic [N-1:0]     pc_plus4;
   logic             taken;
   logic             misalign_err;
   logic [N-1:0]     err_pc;
   logic [CNT_W-1:0] taken_count;

   modport master (
      output en, is_branch, is_jal, is_jalr, funct3, Data0, Data1, imm,
      input  pc, pc_plus4, taken, misalign_err, err_pc, taken_count
   );

   modport slave (
      input  en, is_branch, is_jal, is_jalr, funct3, Data0, Data1, imm,
      output pc, pc_plus4, taken, misalign_err, err_pc, taken_count
   );

endinterface

// File: rtl/Nbit_Equal_Comp.sv
// -----------------------------------------------------------------------------
// Nbit_Equal_Comp
// N-bit equality comparator shared with the rest of the core.
// Ports:
//   Data0, Data1 : operands
//   eq           : 1 when the operands are bit-for-bit identical
// -----------------------------------------------------------------------------
module Nbit_Equal_Comp #(
   parameter int N = 32
) (
   input  logic [N-1:0] Data0,
   input  logic [N-1:0] Data1,
   output logic         eq
);

   assign eq = (Data0 == Data1);

endmodule

// File: rtl/branch_pc_unit.sv
// -----------------------------------------------------------------------------
// branch_pc_unit
// Program-counter register and branch-resolution stage of the single-cycle
// RISC-V core.  Resolves BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL and JALR, keeps the
// architectural PC, provides the link value, raises a sticky trap on a
// misaligned transfer target and counts committed taken transfers.
// Ports:
//   clk   : core clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : branch_pc_unit_if slave modport (instruction fields, operands,
//           PC, link value, taken, trap flag/PC, taken counter)
// -----------------------------------------------------------------------------
module branch_pc_unit
   import branch_pc_unit_pkg::*;
#(
   parameter int           N        = 32,
   parameter logic [N-1:0] RESET_PC = N'(DEFAULT_RESET_PC),
   parameter int           CNT_W    = 16
) (
   input logic             clk,
   input logic             rst_n,
   branch_pc_unit_if.slave bus
);

   logic [N-1:0]     pc_q;
   logic [N-1:0]     err_pc_q;
   logic             err_q;
   logic [CNT_W-1:0] count_q;

   logic             eq;
   logic             lt;
   logic             ltu;
   logic             cond;
   logic             taken;
   logic [N-1:0]     pc_plus4;
   logic [N-1:0]     branch_target;
   logic [N-1:0]     jalr_sum;
   logic [N-1:0]     target;
   logic             target_ok;

   // Equality comes from the shared comparator so every equality test in
   // the core resolves identically.
   Nbit_Equal_Comp #(.N(N)) u_eq (
      .Data0 (bus.Data0),
      .Data1 (bus.Data1),
      .eq    (eq)
   );

   assign lt  = $signed(bus.Data0) < $signed(bus.Data1);
   assign ltu = bus.Data0 < bus.Data1;

   // Branch condition selected by funct3.  The two unused encodings resolve
   // to "not taken" and deliberately do not raise any error.
   always_comb begin
      cond = 1'b0;
      case (bus.funct3)
         F3_BEQ:  cond = eq;
         F3_BNE:  cond = !eq;
         F3_BLT:  cond = lt;
         F3_BGE:  cond = !lt;
         F3_BLTU: cond = ltu;
         F3_BGEU: cond = !ltu;
         default: cond = 1'b0;
      endcase
   end

   assign taken = bus.is_jalr | bus.is_jal | (bus.is_branch & cond);

   // JAL and conditional branches share the PC-relative target, so only
   // JALR needs to win the priority over the others when choosing a target.
   // JALR clears bit 0 of its sum before the alignment test, so only bit 1
   // can make a JALR target misaligned.
   assign pc_plus4      = pc_q + N'(4);
   assign branch_target = pc_q + bus.imm;
   assign jalr_sum      = bus.Data0 + bus.imm;

   always_comb begin
      target = branch_target;
      if (bus.is_jalr) begin
         target = {jalr_sum[N-1:1], 1'b0};
      end
   end

   assign target_ok = word_aligned(target[1:0]);

   // Architectural state.  Once the trap flag is set everything freezes so
   // the trap handler sees exactly the state at the faulting instruction;
   // only reset releases it.  A misaligned transfer neither moves the PC
   // nor counts as a committed transfer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         err_q    <= 1'b0;
         err_pc_q <= '0;
         count_q  <= '0;
      end else if (bus.en && !err_q) begin
         if (taken) begin
            if (target_ok) begin
               pc_q    <= target;
               count_q <= count_q + CNT_W'(1);
            end else begin
               err_q    <= 1'b1;
               err_pc_q <= pc_q;
            end
         end else begin
            pc_q <= pc_plus4;
         end
      end
   end

   assign bus.pc           = pc_q;
   assign bus.pc_plus4     = pc_plus4;
   assign bus.taken        = taken;
   assign bus.misalign_err = err_q;
   assign bus.err_pc       = err_pc_q;
   assign bus.taken_count  = count_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_pc_unit
// Self-checking bench for branch_pc_unit.  A behavioural model computes the
// expected PC, trap state and counter from the ISA rules using plain integer
// arithmetic; each scenario task drives stimulus and checks the DUT inline.
// -----------------------------------------------------------------------------
module tb_branch_pc_unit;

   logic clk;
   logic rst_n;

   int tests;
   int failures;

   // Stimulus as last applied; the model reads these, never the DUT.
   bit        s_rst_n;
   bit        s_en, s_br, s_jal, s_jalr;
   bit [2:0]  s_f3;
   bit [31:0] s_a, s_b, s_imm;

   // Reference state.
   bit [31:0]   ref_pc;
   bit          ref_err;
   bit [31:0]   ref_err_pc;
   int unsigned ref_cnt;

   branch_pc_unit_if #(.N(32), .CNT_W(16)) bus ();

   branch_pc_unit #(
      .N        (32),
      .RESET_PC (32'h0000_0000),
      .CNT_W    (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always terminates.
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // ---------------- behavioural reference model ----------------
   function automatic bit model_cond(bit [2:0] f3, bit [31:0] a, bit [31:0] b);
      int sa;
      int sb;
      sa = int'(a);
      sb = int'(b);
      case (f3)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return sa < sb;
         3'd5:    return sa >= sb;
         3'd6:    return a < b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit model_taken();
      return s_jalr || s_jal || (s_br && model_cond(s_f3, s_a, s_b));
   endfunction

   function automatic bit [31:0] model_target();
      if (s_jalr) return (s_a + s_imm) & 32'hFFFF_FFFE;
      return ref_pc + s_imm;
   endfunction

   function automatic void model_update();
      bit [31:0] t;
      if (!s_rst_n) begin
         ref_pc     = 32'h0;
         ref_err    = 1'b0;
         ref_err_pc = 32'h0;
         ref_cnt    = 0;
      end else if (s_en && !ref_err) begin
         if (model_taken()) begin
            t = model_target();
            if (t % 4 != 0) begin
               ref_err    = 1'b1;
               ref_err_pc = ref_pc;
            end else begin
               ref_pc  = t;
               ref_cnt = (ref_cnt + 1) % 65536;
            end
         end else begin
            ref_pc = ref_pc + 4;
         end
      end
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic applyStimulus(bit rn, bit en, bit br, bit jal, bit jalr,
                                bit [2:0] f3, bit [31:0] a, bit [31:0] b,
                                bit [31:0] imm);
      s_rst_n = rn;  s_en = en;  s_br = br;  s_jal = jal;  s_jalr = jalr;
      s_f3 = f3;     s_a = a;    s_b = b;    s_imm = imm;
      rst_n         = rn;
      bus.en        = en;
      bus.is_branch = br;
      bus.is_jal    = jal;
      bus.is_jalr   = jalr;
      bus.funct3    = f3;
      bus.Data0     = a;
      bus.Data1     = b;
      bus.imm       = imm;
      #2;
   endtask

   // Advance one clock; outputs are sampled 1 unit after the edge.
   task automatic clockEdge();
      @(posedge clk);
      model_update();
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      // Reset asserted while stalled and with a transfer requested.
      applyStimulus(0, 0, 0, 1, 0, 3'd0, 32'h5, 32'h6, 32'h40);
      clockEdge();
      clockEdge();
      tests++; if (bus.pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc: got %h expected %h", bus.pc, 32'h0); end
      tests++; if (bus.misalign_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", bus.misalign_err); end
      tests++; if (bus.err_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_err_pc: got %h expected 0", bus.err_pc); end
      tests++; if (bus.taken_count !== 16'h0) begin failures++; $display("[TB] FAIL reset_count: got %h expected 0", bus.taken_count); end
   endtask

   task automatic test_sequential();
      bit [31:0] exp_seq [3] = '{32'h4, 32'h8, 32'hC};
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 0, 0, 0, 3'd0, $urandom, $urandom, $urandom);
         tests++; if (bus.taken !== 1'b0) begin failures++; $display("[TB] FAIL seq_taken[%0d]: got %b expected 0", i, bus.taken); end
         tests++; if (bus.pc_plus4 !== ref_pc + 32'd4) begin failures++; $display("[TB] FAIL seq_plus4[%0d]: got %h expected %h", i, bus.pc_plus4, ref_pc + 32'd4); end
         clockEdge();
         tests++; if (bus.pc !== exp_seq[i] || ref_pc !== exp_seq[i]) begin failures++; $display("[TB] FAIL seq_pc[%0d]: got %h expected %h", i, bus.pc, exp_seq[i]); end
      end
      tests++; if (bus.taken_count !== 16'h0) begin failures++; $display("[TB] FAIL seq_count: got %h expected 0", bus.taken_count); end
   endtask

   task automatic test_branch_eq();
      applyStimulus(1, 1, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0);
      clockEdge();
      tests++; if (bus.pc !== 32'h10) begin failures++; $display("[TB] FAIL beq_start_pc: got %h expected 10", bus.pc); end
      applyStimulus(1, 1, 1, 0, 0, 3'd0, 32'h0123_4567, 32'h0123_4567, 32'h20);
      tests++; if (bus.taken !== 1'b1) begin failures++; $display("[TB] FAIL beq_taken: got %b expected 1", bus.taken); end
      clockEdge();
      tests++; if (bus.pc !== 32'h30) begin failures++; $display("[TB] FAIL beq_pc: got %h expected 30", bus.pc); end
      tests++; if (bus.taken_count !== 16'd1) begin failures++; $display("[TB] FAIL beq_count: got %h expected 1", bus.taken_count); end
      applyStimulus(1, 1, 1, 0, 0, 3'd0, 32'h0123_4567, 32'h0123_4568, 32'h20);
      tests++; if (bus.taken !== 1'b0) begin failures++; $display("[TB] FAIL beq_ne_taken: got %b expected 0", bus.taken); end
      clockEdge();
      tests++; if (bus.pc !== 32'h34) begin failures++; $display("[TB] FAIL beq_ne_pc: got %h expected 34", bus.pc); end
   endtask

   task automatic test_signed_compare();
      bit [2:0] codes [6] = '{3'd4, 3'd6, 3'd7, 3'd5, 3'd2, 3'd3};
      bit       exp_t [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1, 0, 1, 0, 0, codes[i], 32'hFFFF_FFFF, 32'h1, 32'h8);
         tests++; if (bus.taken !== exp_t[i]) begin failures++; $display("[TB] FAIL cmp_taken f3=%0d: got %b expected %b", codes[i], bus.taken, exp_t[i]); end
      end
      // Illegal funct3 commits as a fall-through without any trap.
      applyStimulus(1, 1, 1, 0, 0, 3'd2, 32'h7, 32'h7, 32'h2);
      clockEdge();
      tests++; if (bus.pc !== 32'h38 || bus.misalign_err !== 1'b0) begin failures++; $display("[TB] FAIL illegal_f3: got pc %h err %b expected pc 38 err 0", bus.pc, bus.misalign_err); end
      applyStimulus(1, 1, 1, 0, 0, 3'd7, 32'hFFFF_FFFF, 32'h1, 32'h8);
      clockEdge();
      tests++; if (bus.pc !== 32'h40) begin failures++; $display("[TB] FAIL bgeu_pc: got %h expected 40", bus.pc); end
      tests++; if (bus.taken_count !== 16'd2) begin failures++; $display("[TB] FAIL bgeu_count: got %h expected 2", bus.taken_count); end
   endtask

   task automatic test_stall();
      bit [31:0]   held_pc;
      int unsigned held_cnt;
      held_pc  = ref_pc;
      held_cnt = ref_cnt;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 0, 1, 0, 0, 3'd1, 32'h1, 32'h2, 32'h40);
         tests++; if (bus.taken !== 1'b1) begin failures++; $display("[TB] FAIL stall_taken[%0d]: got %b expected 1", i, bus.taken); end
         clockEdge();
         tests++; if (bus.pc !== held_pc || bus.taken_count !== 16'(held_cnt)) begin failures++; $display("[TB] FAIL stall_hold[%0d]: got pc %h cnt %h expected pc %h cnt %h", i, bus.pc, bus.taken_count, held_pc, 16'(held_cnt)); end
      end
      applyStimulus(1, 1, 1, 0, 0, 3'd1, 32'h1, 32'h2, 32'h40);
      clockEdge();
      tests++; if (bus.pc !== held_pc + 32'h40 || bus.taken_count !== 16'(held_cnt + 1)) begin failures++; $display("[TB] FAIL stall_release: got pc %h cnt %h expected pc %h cnt %h", bus.pc, bus.taken_count, held_pc + 32'h40, 16'(held_cnt + 1)); end
      applyStimulus(1, 1, 0, 0, 0, 3'd1, 32'h1, 32'h2, 32'h40);
      clockEdge();
      tests++; if (bus.pc !== held_pc + 32'h44 || bus.taken_count !== 16'(held_cnt + 1)) begin failures++; $display("[TB] FAIL stall_single: got pc %h cnt %h expected pc %h cnt %h", bus.pc, bus.taken_count, held_pc + 32'h44, 16'(held_cnt + 1)); end
   endtask

   task automatic test_misalign();
      bit [31:0]   trap_pc;
      int unsigned trap_cnt;
      trap_pc  = ref_pc;
      trap_cnt = ref_cnt;
      applyStimulus(1, 1, 0, 0, 1, 3'd0, 32'h0000_0103, 32'h0, 32'h0);
      tests++; if (bus.taken !== 1'b1) begin failures++; $display("[TB] FAIL jalr_taken: got %b expected 1", bus.taken); end
      tests++; if (bus.pc_plus4 !== trap_pc + 32'd4) begin failures++; $display("[TB] FAIL jalr_link: got %h expected %h", bus.pc_plus4, trap_pc + 32'd4); end
      clockEdge();
      tests++; if (bus.misalign_err !== 1'b1) begin failures++; $display("[TB] FAIL trap_flag: got %b expected 1", bus.misalign_err); end
      tests++; if (bus.err_pc !== trap_pc) begin failures++; $display("[TB] FAIL trap_err_pc: got %h expected %h", bus.err_pc, trap_pc); end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 1, (i % 2) == 0, i == 1, 0, 3'd0, 32'h0, 32'h0, 32'h100);
         clockEdge();
         tests++; if (bus.pc !== trap_pc || bus.misalign_err !== 1'b1 || bus.err_pc !== trap_pc || bus.taken_count !== 16'(trap_cnt)) begin
            failures++; $display("[TB] FAIL trap_frozen[%0d]: got pc %h err %b err_pc %h cnt %h expected pc %h err 1 err_pc %h cnt %h", i, bus.pc, bus.misalign_err, bus.err_pc, bus.taken_count, trap_pc, trap_pc, 16'(trap_cnt));
         end
      end
      applyStimulus(0, 1, 0, 1, 0, 3'd0, 32'h0, 32'h0, 32'h8);
      clockEdge();
      tests++; if (bus.pc !== 32'h0 || bus.misalign_err !== 1'b0 || bus.err_pc !== 32'h0 || bus.taken_count !== 16'h0) begin
         failures++; $display("[TB] FAIL trap_reset: got pc %h err %b err_pc %h cnt %h expected all zero", bus.pc, bus.misalign_err, bus.err_pc, bus.taken_count);
      end
   endtask

   task automatic test_count_wrap();
      applyStimulus(0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0);
      clockEdge();
      applyStimulus(1, 1, 0, 1, 0, 3'd0, 32'h0, 32'h0, 32'h0);
      for (int i = 0; i < 65535; i++) clockEdge();
      tests++; if (bus.taken_count !== 16'hFFFF || ref_cnt != 32'hFFFF) begin failures++; $display("[TB] FAIL count_full: got %h expected ffff", bus.taken_count); end
      tests++; if (bus.pc !== 32'h0) begin failures++; $display("[TB] FAIL count_pc: got %h expected 0", bus.pc); end
      clockEdge();
      tests++; if (bus.taken_count !== 16'h0000) begin failures++; $display("[TB] FAIL count_wrap: got %h expected 0000", bus.taken_count); end
   endtask

   task automatic test_pc_wrap();
      // JAL back 8 from 0 lands at 0xFFFFFFF8; two fall-throughs then wrap to 0.
      applyStimulus(1, 1, 0, 1, 0, 3'd0, 32'h0, 32'h0, 32'hFFFF_FFF8);
      clockEdge();
      applyStimulus(1, 1, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0);
      clockEdge();
      clockEdge();
      tests++; if (bus.pc !== 32'h0 || ref_pc !== 32'h0) begin failures++; $display("[TB] FAIL pc_wrap: got %h expected 0", bus.pc); end
   endtask

   task automatic test_random();
      bit        rn, en, br, jal, jalr;
      bit [2:0]  f3;
      bit [31:0] a, b, imm;
      for (int i = 0; i < 600; i++) begin
         rn   = ($urandom_range(99) >= 3);
         en   = ($urandom_range(99) < 85);
         br   = $urandom_range(1);
         jal  = ($urandom_range(5) == 0);
         jalr = ($urandom_range(5) == 0);
         f3   = 3'($urandom_range(7));
         a    = $urandom;
         b    = ($urandom_range(3) == 0) ? a : $urandom;
         imm  = $urandom;
         if ($urandom_range(9) != 0) imm = imm & 32'hFFFF_FFFC;
         if ($urandom_range(3) != 0) a = a & 32'hFFFF_FFFC;
         // Leave a trap in place for a while before reset clears it.
         if (ref_err && $urandom_range(7) == 0) rn = 1'b0;
         applyStimulus(rn, en, br, jal, jalr, f3, a, b, imm);
         tests++; if (bus.taken !== model_taken()) begin failures++; $display("[TB] FAIL rand_taken[%0d]: got %b expected %b", i, bus.taken, model_taken()); end
         tests++; if (bus.pc_plus4 !== ref_pc + 32'd4) begin failures++; $display("[TB] FAIL rand_plus4[%0d]: got %h expected %h", i, bus.pc_plus4, ref_pc + 32'd4); end
         clockEdge();
         tests++; if (bus.pc !== ref_pc || bus.misalign_err !== ref_err || bus.err_pc !== ref_err_pc || bus.taken_count !== 16'(ref_cnt)) begin
            failures++; $display("[TB] FAIL rand_state[%0d]: got pc %h err %b err_pc %h cnt %h expected pc %h err %b err_pc %h cnt %h", i, bus.pc, bus.misalign_err, bus.err_pc, bus.taken_count, ref_pc, ref_err, ref_err_pc, 16'(ref_cnt));
         end
      end
   endtask

   // Scenario sequence.
   initial begin
      tests    = 0;
      failures = 0;
      ref_pc     = 32'h0;
      ref_err    = 1'b0;
      ref_err_pc = 32'h0;
      ref_cnt    = 0;
      test_reset();
      test_sequential();
      test_branch_eq();
      test_signed_compare();
      test_stall();
      test_misalign();
      test_count_wrap();
      test_pc_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
